// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic {
    REQ_CPU,
    REQ_DMA
  } req_id_t;

endpackage

// File: rtl/dmem_rr_arbiter.sv
// Two-way round-robin grant. Bit 0 = CPU, bit 1 = DMA.
// last_grant resets to DMA so the CPU wins the first tie.
module dmem_rr_arbiter
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  req_id_t last_grant_reg;

  // Tie goes to whoever was not granted last; a lone requester always wins.
  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) begin
      grant = (last_grant_reg == REQ_DMA) ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end

  // Remember the winner only when a grant is actually taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= REQ_DMA;
    end else if (advance && (grant != 2'b00)) begin
      last_grant_reg <= grant[1] ? REQ_DMA : REQ_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one byte-addressed data memory between CPU and DMA requesters.
// Each transfer runs IDLE (handshake) -> ACCESS (memory enable) -> RESP.
// Optional macro DMEM_ARB_ALIGN_CHK_EN: unaligned requests skip ACCESS and
// answer with rsp_err=1 one cycle after accept.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = dmem_arb_pkg::ADDR_W,
  parameter int DATA_W = dmem_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_rdata,
  output logic              cpu_rsp_err,
  input  logic              dma_req_valid,
  output logic              dma_req_ready,
  input  logic              dma_req_we,
  input  logic [ADDR_W-1:0] dma_req_addr,
  input  logic [DATA_W-1:0] dma_req_wdata,
  output logic              dma_rsp_valid,
  output logic [DATA_W-1:0] dma_rsp_rdata,
  output logic              dma_rsp_err,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t              state_reg, state_next;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  req_id_t             id_reg;
  logic                err_reg;

  logic [1:0]          grant;
  logic                advance;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                accept_err;
  logic [DATA_W-1:0]   rsp_rdata;

  assign advance = (state_reg == IDLE) && !reset;

  dmem_rr_arbiter u_rr (
    .clk     (clk),
    .reset   (reset),
    .valid   ({dma_req_valid, cpu_req_valid}),
    .advance (advance),
    .grant   (grant)
  );

  // Request fields of whichever side holds the grant.
  assign sel_we    = grant[1] ? dma_req_we    : cpu_req_we;
  assign sel_addr  = grant[1] ? dma_req_addr  : cpu_req_addr;
  assign sel_wdata = grant[1] ? dma_req_wdata : cpu_req_wdata;

`ifdef DMEM_ARB_ALIGN_CHK_EN
  assign accept_err = (sel_addr[1:0] != 2'b00);
`else
  assign accept_err = 1'b0;
`endif

  // Writes and rejected accesses return zero data.
  assign rsp_rdata = (we_reg || err_reg) ? '0 : mem_rdata;

  // Next state and all outputs; everything is held low while in reset.
  always_comb begin
    state_next    = state_reg;
    cpu_req_ready = 1'b0;
    dma_req_ready = 1'b0;
    cpu_rsp_valid = 1'b0;
    cpu_rsp_rdata = '0;
    cpu_rsp_err   = 1'b0;
    dma_rsp_valid = 1'b0;
    dma_rsp_rdata = '0;
    dma_rsp_err   = 1'b0;
    mem_en        = 1'b0;
    mem_rw        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    case (state_reg)
      IDLE: begin
        if (grant != 2'b00) begin
          cpu_req_ready = grant[0];
          dma_req_ready = grant[1];
          state_next    = accept_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        mem_en     = 1'b1;
        mem_rw     = we_reg;
        mem_addr   = addr_reg;
        mem_wdata  = wdata_reg;
        state_next = RESP;
      end
      RESP: begin
        if (id_reg == REQ_CPU) begin
          cpu_rsp_valid = 1'b1;
          cpu_rsp_rdata = rsp_rdata;
          cpu_rsp_err   = err_reg;
        end else begin
          dma_rsp_valid = 1'b1;
          dma_rsp_rdata = rsp_rdata;
          dma_rsp_err   = err_reg;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (reset) begin
      cpu_req_ready = 1'b0;
      dma_req_ready = 1'b0;
      cpu_rsp_valid = 1'b0;
      cpu_rsp_rdata = '0;
      cpu_rsp_err   = 1'b0;
      dma_rsp_valid = 1'b0;
      dma_rsp_rdata = '0;
      dma_rsp_err   = 1'b0;
      mem_en        = 1'b0;
      mem_rw        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
    end
  end

  // State register and request latches captured on the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      id_reg    <= REQ_CPU;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && (grant != 2'b00)) begin
        we_reg    <= sel_we;
        addr_reg  <= sel_addr;
        wdata_reg <= sel_wdata;
        id_reg    <= grant[1] ? REQ_DMA : REQ_CPU;
        err_reg   <= accept_err;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a byte-array memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [9:0]  cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic        cpu_rsp_valid, cpu_rsp_err;
  logic [31:0] cpu_rsp_rdata;
  logic        dma_req_valid, dma_req_ready, dma_req_we;
  logic [9:0]  dma_req_addr;
  logic [31:0] dma_req_wdata;
  logic        dma_rsp_valid, dma_rsp_err;
  logic [31:0] dma_rsp_rdata;
  logic        mem_en, mem_rw;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [31:0] VAL_A = 32'hA5A5_0020;
  localparam logic [31:0] VAL_B = 32'h5A5A_0024;

  logic [7:0] mem [0:1023];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata), .cpu_rsp_err(cpu_rsp_err),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_req_we(dma_req_we),
    .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
    .dma_rsp_valid(dma_rsp_valid), .dma_rsp_rdata(dma_rsp_rdata), .dma_rsp_err(dma_rsp_err),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory model: preload, then one-cycle registered read, little-endian bytes.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    {mem[7], mem[6], mem[5], mem[4]} = 32'h9912_7254;
    {mem[35], mem[34], mem[33], mem[32]} = VAL_A;
    {mem[39], mem[38], mem[37], mem[36]} = VAL_B;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_rw) begin
          mem[int'(mem_addr)]                 <= mem_wdata[7:0];
          mem[(int'(mem_addr) + 1) & 1023]    <= mem_wdata[15:8];
          mem[(int'(mem_addr) + 2) & 1023]    <= mem_wdata[23:16];
          mem[(int'(mem_addr) + 3) & 1023]    <= mem_wdata[31:24];
        end else begin
          mem_rdata <= {mem[(int'(mem_addr) + 3) & 1023], mem[(int'(mem_addr) + 2) & 1023],
                        mem[(int'(mem_addr) + 1) & 1023], mem[int'(mem_addr)]};
        end
      end
    end
  end

  task automatic reset_pulse();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Issue one request from an idle bus and observe three cycles.
  task automatic run_xfer(input logic is_dma, input logic we, input logic [9:0] addr,
                          input logic [31:0] wdata, output logic rdy, output int rsp_cyc,
                          output logic [31:0] rdata, output logic err, output logic en_seen,
                          output logic [9:0] en_addr, output logic en_rw,
                          output logic [31:0] en_wdata, output logic other_rsp);
    rdy = 0; rsp_cyc = -1; rdata = '0; err = 0; en_seen = 0;
    en_addr = '0; en_rw = 0; en_wdata = '0; other_rsp = 0;
    if (is_dma) begin
      dma_req_valid = 1; dma_req_we = we; dma_req_addr = addr; dma_req_wdata = wdata;
    end else begin
      cpu_req_valid = 1; cpu_req_we = we; cpu_req_addr = addr; cpu_req_wdata = wdata;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) rdy = is_dma ? dma_req_ready : cpu_req_ready;
      if (mem_en) begin
        en_seen = 1; en_addr = mem_addr; en_rw = mem_rw; en_wdata = mem_wdata;
      end
      if (is_dma ? dma_rsp_valid : cpu_rsp_valid) begin
        rsp_cyc = c;
        rdata = is_dma ? dma_rsp_rdata : cpu_rsp_rdata;
        err = is_dma ? dma_rsp_err : cpu_rsp_err;
      end
      if (is_dma ? cpu_rsp_valid : dma_rsp_valid) other_rsp = 1;
      @(posedge clk); #1;
      if (c == 0) begin
        cpu_req_valid = 0;
        dma_req_valid = 0;
      end
    end
    $display("xfer %s we=%0d addr=%h rdy=%0d rsp_cyc=%0d rdata=%h err=%0d",
             is_dma ? "DMA" : "CPU", we, addr, rdy, rsp_cyc, rdata, err);
  endtask

  task automatic test_reset();
    reset = 1; cpu_req_valid = 1; cpu_req_we = 0; cpu_req_addr = 10'h004; cpu_req_wdata = 0;
    dma_req_valid = 0; dma_req_we = 0; dma_req_addr = 0; dma_req_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (cpu_req_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", cpu_req_ready);
    else pass_cnt++;
    total_cnt++;
    if ({mem_en, mem_rw, mem_addr, mem_wdata, cpu_rsp_valid, dma_rsp_valid} !== '0)
      $display("FAIL reset_outputs got en=%b rw=%b addr=%h", mem_en, mem_rw, mem_addr);
    else pass_cnt++;
    @(posedge clk); #1;
    reset = 0; cpu_req_valid = 0;
    @(negedge clk);
    total_cnt++;
    if ({cpu_req_ready, dma_req_ready, mem_en, cpu_rsp_valid, dma_rsp_valid} !== 5'b0)
      $display("FAIL idle_outputs got=%b exp=00000",
               {cpu_req_ready, dma_req_ready, mem_en, cpu_rsp_valid, dma_rsp_valid});
    else pass_cnt++;
    $display("xfer reset done");
    @(posedge clk); #1;
  endtask

  task automatic test_cpu_read();
    logic rdy, err, en, rw, oth; int rc; logic [31:0] rd, wd; logic [9:0] ea;
    run_xfer(0, 0, 10'h004, 32'h0, rdy, rc, rd, err, en, ea, rw, wd, oth);
    total_cnt++;
    if (rdy !== 1'b1) $display("FAIL cpu_read_ready got=%b exp=1", rdy); else pass_cnt++;
    total_cnt++;
    if (en !== 1'b1 || ea !== 10'h004 || rw !== 1'b0)
      $display("FAIL cpu_read_mem got en=%b addr=%h rw=%b exp en=1 addr=004 rw=0", en, ea, rw);
    else pass_cnt++;
    total_cnt++;
    if (rc !== 2) $display("FAIL cpu_read_latency got=%0d exp=2", rc); else pass_cnt++;
    total_cnt++;
    if (rd !== 32'h9912_7254) $display("FAIL cpu_read_data got=%h exp=99127254", rd);
    else pass_cnt++;
    total_cnt++;
    if (oth !== 1'b0) $display("FAIL cpu_read_dma_rsp got=%b exp=0", oth); else pass_cnt++;
  endtask

  task automatic test_write_then_read();
    logic rdy, err, en, rw, oth; int rc; logic [31:0] rd, wd; logic [9:0] ea;
    run_xfer(1, 1, 10'h010, 32'h1234_5678, rdy, rc, rd, err, en, ea, rw, wd, oth);
    total_cnt++;
    if (rdy !== 1'b1 || rc !== 2 || rd !== 32'h0)
      $display("FAIL dma_write_ack got rdy=%b cyc=%0d rdata=%h exp rdy=1 cyc=2 rdata=0", rdy, rc, rd);
    else pass_cnt++;
    total_cnt++;
    if (en !== 1'b1 || ea !== 10'h010 || rw !== 1'b1 || wd !== 32'h1234_5678)
      $display("FAIL dma_write_mem got en=%b addr=%h rw=%b wdata=%h", en, ea, rw, wd);
    else pass_cnt++;
    total_cnt++;
    if ({mem[19], mem[18], mem[17], mem[16]} !== 32'h1234_5678)
      $display("FAIL dma_write_bytes got=%h %h %h %h exp=78 56 34 12",
               mem[16], mem[17], mem[18], mem[19]);
    else pass_cnt++;
    run_xfer(0, 0, 10'h010, 32'h0, rdy, rc, rd, err, en, ea, rw, wd, oth);
    total_cnt++;
    if (rc !== 2 || rd !== 32'h1234_5678)
      $display("FAIL cpu_readback got cyc=%0d rdata=%h exp cyc=2 rdata=12345678", rc, rd);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int grants = 0, rsps = 0, cpu_n = 0, dma_n = 0;
    reset_pulse();
    cpu_req_valid = 1; cpu_req_we = 0; cpu_req_addr = 10'h020;
    dma_req_valid = 1; dma_req_we = 0; dma_req_addr = 10'h024;
    for (int cyc = 0; cyc < 40 && !(grants == 8 && rsps == 8); cyc++) begin
      @(negedge clk);
      if (cpu_req_ready && dma_req_ready) begin
        total_cnt++;
        $display("FAIL rr_ready_overlap got both ready at cycle %0d exp one", cyc);
      end
      if (cpu_req_ready || dma_req_ready) begin
        total_cnt++;
        if (dma_req_ready !== logic'(grants % 2) || cyc != 3 * grants)
          $display("FAIL rr_grant got dma=%b cyc=%0d exp dma=%0d cyc=%0d",
                   dma_req_ready, cyc, grants % 2, 3 * grants);
        else pass_cnt++;
        $display("xfer grant %s at cycle %0d", dma_req_ready ? "DMA" : "CPU", cyc);
        if (cpu_req_ready) cpu_n++;
        if (dma_req_ready) dma_n++;
        grants++;
      end
      if (cpu_rsp_valid) begin
        total_cnt++;
        if (cpu_rsp_rdata !== VAL_A) $display("FAIL rr_cpu_data got=%h exp=%h", cpu_rsp_rdata, VAL_A);
        else pass_cnt++;
        rsps++;
      end
      if (dma_rsp_valid) begin
        total_cnt++;
        if (dma_rsp_rdata !== VAL_B) $display("FAIL rr_dma_data got=%h exp=%h", dma_rsp_rdata, VAL_B);
        else pass_cnt++;
        rsps++;
      end
      @(posedge clk); #1;
      if (cpu_n == 4) cpu_req_valid = 0;
      if (dma_n == 4) dma_req_valid = 0;
    end
    cpu_req_valid = 0; dma_req_valid = 0;
    total_cnt++;
    if (grants != 8 || rsps != 8) $display("FAIL rr_count got grants=%0d rsps=%0d exp 8/8", grants, rsps);
    else pass_cnt++;
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    cpu_req_valid = 1; cpu_req_we = 0; cpu_req_addr = 10'h004;
    @(negedge clk);
    total_cnt++;
    if (cpu_req_ready !== 1'b1) $display("FAIL midrst_accept got=%b exp=1", cpu_req_ready); else pass_cnt++;
    @(posedge clk); #1;
    cpu_req_valid = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total_cnt++;
      if (cpu_rsp_valid !== 1'b0 || mem_en !== 1'b0)
        $display("FAIL midrst_quiet got rsp=%b en=%b exp 0 0 (cycle %0d)", cpu_rsp_valid, mem_en, c);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    cpu_req_valid = 1; cpu_req_addr = 10'h020;
    dma_req_valid = 1; dma_req_addr = 10'h024;
    @(negedge clk);
    total_cnt++;
    if (cpu_req_ready !== 1'b1 || dma_req_ready !== 1'b0)
      $display("FAIL midrst_tie got cpu=%b dma=%b exp cpu=1 dma=0", cpu_req_ready, dma_req_ready);
    else pass_cnt++;
    $display("xfer reset-during-access tie cpu=%b dma=%b", cpu_req_ready, dma_req_ready);
    @(posedge clk); #1;
    cpu_req_valid = 0; dma_req_valid = 0;
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_align();
    logic rdy, err, en, rw, oth; int rc; logic [31:0] rd, wd; logic [9:0] ea;
    run_xfer(0, 1, 10'h006, 32'hCAFE_F00D, rdy, rc, rd, err, en, ea, rw, wd, oth);
`ifdef DMEM_ARB_ALIGN_CHK_EN
    total_cnt++;
    if (en !== 1'b0) $display("FAIL align_mem_en got=%b exp=0", en); else pass_cnt++;
    total_cnt++;
    if (rc !== 1 || err !== 1'b1 || rd !== 32'h0)
      $display("FAIL align_err got cyc=%0d err=%b rdata=%h exp cyc=1 err=1 rdata=0", rc, err, rd);
    else pass_cnt++;
    total_cnt++;
    if ({mem[9], mem[8], mem[7], mem[6]} !== 32'h0000_9912)
      $display("FAIL align_untouched got=%h exp=00009912", {mem[9], mem[8], mem[7], mem[6]});
    else pass_cnt++;
`else
    total_cnt++;
    if (en !== 1'b1 || ea !== 10'h006 || rw !== 1'b1)
      $display("FAIL unaligned_pass got en=%b addr=%h rw=%b exp en=1 addr=006 rw=1", en, ea, rw);
    else pass_cnt++;
    total_cnt++;
    if (rc !== 2 || err !== 1'b0)
      $display("FAIL unaligned_err got cyc=%0d err=%b exp cyc=2 err=0", rc, err);
    else pass_cnt++;
`endif
  endtask

  task automatic test_single_dma();
    int grants = 0;
    reset_pulse();
    dma_req_valid = 1; dma_req_we = 0; dma_req_addr = 10'h024;
    for (int cyc = 0; cyc < 15 && grants < 3; cyc++) begin
      @(negedge clk);
      if (cpu_req_ready) begin
        total_cnt++;
        $display("FAIL single_cpu_ready got=1 exp=0 at cycle %0d", cyc);
      end
      if (dma_req_ready) begin
        total_cnt++;
        if (cyc != 3 * grants) $display("FAIL single_dma_cycle got=%0d exp=%0d", cyc, 3 * grants);
        else pass_cnt++;
        $display("xfer single DMA grant at cycle %0d", cyc);
        grants++;
      end
      if (dma_rsp_valid) begin
        total_cnt++;
        if (dma_rsp_rdata !== VAL_B) $display("FAIL single_dma_data got=%h exp=%h", dma_rsp_rdata, VAL_B);
        else pass_cnt++;
      end
      @(posedge clk); #1;
      if (grants == 3) dma_req_valid = 0;
    end
    dma_req_valid = 0;
    total_cnt++;
    if (grants != 3) $display("FAIL single_dma_count got=%0d exp=3", grants); else pass_cnt++;
    repeat (3) @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_write_then_read();
    test_round_robin();
    test_reset_mid();
    test_align();
    test_single_dma();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
